regfile_mp: RTL

//  Parametrised multi-port register file with write-to-read bypass and per-register busy scoreboard.

---
 rtl/regfile_mp.sv | 120 ++++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with write-to-read bypass and busy scoreboard
module regfile_mp #(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 32,
    parameter int NRD       = 2,
    parameter int NWR       = 1,
    parameter int ZERO_REG  = 1,
    parameter int RST_ARRAY = 0,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                aresetn,
    input  logic [NRD-1:0]      i_rden,
    input  logic [NRD*AW-1:0]   i_raddr,
    output logic [NRD*XLEN-1:0] o_rdata,
    output logic [NRD-1:0]      o_rbusy,
    input  logic [NWR-1:0]      i_wren,
    input  logic [NWR*AW-1:0]   i_waddr,
    input  logic [NWR*XLEN-1:0] i_wdata,
    input  logic                i_rsv,
    input  logic [AW-1:0]       i_rsv_addr,
    output logic [DEPTH-1:0]    o_busy_vec
);

    logic [XLEN-1:0]     w_mem [DEPTH];
    logic [DEPTH-1:0]    r_busy;
    logic [DEPTH-1:0]    w_busy_nxt;
    logic [NRD*XLEN-1:0] r_rdata;
    logic [NRD-1:0]      r_rbusy;
    logic [NRD*XLEN-1:0] w_rd_data;
    logic [NRD-1:0]      w_rd_busy;

    // One storage word per register; ascending port scan lets the higher port win.
    for (genvar g = 0; g < DEPTH; g++) begin : g_reg
        logic [XLEN-1:0] r_q;
        logic            w_we;
        logic [XLEN-1:0] w_wd;

        always_comb begin
            w_we = 1'b0;
            w_wd = r_q;
            for (int p = 0; p < NWR; p++) begin
                if (i_wren[p] && (i_waddr[p*AW +: AW] == AW'(g))) begin
                    w_we = 1'b1;
                    w_wd = i_wdata[p*XLEN +: XLEN];
                end
            end
            if ((ZERO_REG != 0) && (g == 0)) begin
                w_we = 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (!aresetn && (RST_ARRAY != 0)) begin
                r_q <= '0;
            end else if (aresetn && w_we) begin
                r_q <= w_wd;
            end
        end

        assign w_mem[g] = r_q;
    end

    // Writes retire producers, a same-edge reserve re-arms the bit.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int p = 0; p < NWR; p++) begin
            if (i_wren[p]) begin
                w_busy_nxt[i_waddr[p*AW +: AW]] = 1'b0;
            end
        end
        if (i_rsv) begin
            w_busy_nxt[i_rsv_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            w_busy_nxt[0] = 1'b0;
        end
    end

    always_comb begin
        w_rd_data = '0;
        w_rd_busy = '0;
        for (int r = 0; r < NRD; r++) begin
            logic [AW-1:0] ra;
            ra = i_raddr[r*AW +: AW];
            w_rd_data[r*XLEN +: XLEN] = w_mem[ra];
            for (int p = 0; p < NWR; p++) begin
                if (i_wren[p] && (i_waddr[p*AW +: AW] == ra)) begin
                    w_rd_data[r*XLEN +: XLEN] = i_wdata[p*XLEN +: XLEN];
                end
            end
            w_rd_busy[r] = w_busy_nxt[ra];
            if ((ZERO_REG != 0) && (ra == '0)) begin
                w_rd_data[r*XLEN +: XLEN] = '0;
                w_rd_busy[r]              = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_busy  <= '0;
            r_rdata <= '0;
            r_rbusy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            for (int r = 0; r < NRD; r++) begin
                if (i_rden[r]) begin
                    r_rdata[r*XLEN +: XLEN] <= w_rd_data[r*XLEN +: XLEN];
                    r_rbusy[r]              <= w_rd_busy[r];
                end
            end
        end
    end

    assign o_rdata    = r_rdata;
    assign o_rbusy    = r_rbusy;
    assign o_busy_vec = r_busy;

endmodule
